alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the same 3-bit opcode map for ops 000–101 and adds a barrel shift-left (110) and an iterative multi-cycle multiply (111). Results carry status flags. Operands enter and results leave through valid/ready handshakes, so the block sits directly in datapath pipelines and tolerates downstream backpressure.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 4–32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand/opcode valid
in_ready  output  1  block can accept a new op this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
opcode  input  3  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  registered result
flag_zero  output  1  result == 0
flag_neg  output  1  result[WIDTH-1]
flag_carry  output  1  carry / borrow / multiply-overflow
flag_ovf  output  1  signed overflow (add/sub only)

Behaviour:
- Reset: the clock and reset are one clock, clk, and a synchronous, active-high reset, rst.
- Reset state: IDLE; result=0, all flags=0, out_valid=0, internal counter and accumulators=0.
- Reset mid-operation: rst aborts any multiply in progress; no result is emitted; in_ready=1 on the first cycle after rst deasserts.
- Accept: an op is taken when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready). Operands are captured at accept; later changes on a/b/opcode are ignored.
- Output hold: while out_valid && !out_ready, result and flags are held stable and no new op is accepted.
- States: IDLE, MUL.
- IDLE, opcode != 111: result and flags load on the accept edge. out_valid is high the next cycle (latency 1). Throughput is 1 op/cycle while out_ready=1.
- IDLE, opcode == 111: go to MUL. Counter loads WIDTH. out_valid drops when the current result is consumed.
- MUL: shift-add one bit of B per cycle, LSB first, into a 2*WIDTH accumulator. After WIDTH iterations, return to IDLE, load result, and set out_valid. Latency from accept to out_valid is WIDTH+1 cycles. in_ready=0 throughout MUL.
- Opcode 000 ADD: result = (A+B) mod 2^WIDTH.
  - carry = bit WIDTH of the sum.
  - ovf = signed overflow.
- Opcode 001 SUB: result = (A-B) mod 2^WIDTH.
  - carry = borrow (unsigned A<B).
  - ovf = signed overflow.
- Opcodes 010 AND, 011 OR, 100 XOR: bitwise A op B. carry=ovf=0.
- Opcode 101 NOT: ~A. carry=ovf=0.
- Opcode 110 SHL: A << B, with B as unsigned shift amount.
  - If B >= WIDTH, result = 0.
  - carry = OR of the bits shifted out.
  - ovf = 0.
- Opcode 111 MUL: result = low WIDTH bits of unsigned A*B.
  - carry = 1 if the high WIDTH bits are nonzero.
  - ovf = 0.
- flag_zero and flag_neg are always derived from the final registered result.

Optional Feature:
ALU_SAT_EN
- Defined: ADD and SUB saturate on signed overflow. Positive overflow gives 0 followed by WIDTH-1 ones (max signed). Negative overflow gives 1 followed by WIDTH-1 zeros (min signed). flag_ovf is still set and flag_carry is unchanged; zero/neg are recomputed from the saturated result.
- Undefined: ADD and SUB wrap modulo 2^WIDTH. No saturation logic is synthesised.

Test Plan (WIDTH=8):
1. ADD a=FF b=01, out_ready=1 -> next cycle out_valid=1, result=00, zero=1, carry=1, ovf=0, neg=0.
2. SUB a=80 b=01 -> result=7F, ovf=1, carry=0, neg=0. With ALU_SAT_EN: result=80, ovf=1, neg=1.
3. MUL 0D×0B -> in_ready=0 for 8 cycles, out_valid 9 cycles after accept, result=8F, carry=0. MUL 14×14 -> result=90, carry=1.
4. Backpressure: ADD 03+04 with out_ready=0 for 3 cycles -> result=07 held stable, in_ready=0. Raise out_ready with a second op (AND F0,3C) presented -> second op accepted that cycle, result=30 the next cycle.
5. Reset on the 4th MUL cycle -> next cycle out_valid=0, result=00, flags=0, in_ready=1. No stale multiply result ever appears.
6. SHL a=81 b=01 -> result=02, carry=1. SHL b=08 -> result=00, zero=1, carry=1. NOT a=0F -> F0, neg=1.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: valid/ready operand request and result/flags response bundle for alu_pipe.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_carry;
    logic             flag_ovf;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_neg, flag_carry, flag_ovf
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered valid/ready ALU with flags and an iterative shift-add multiply.
// Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow instead of wrapping.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [2*WIDTH-1:0] acc, acc_n, mcand, mcand_n, prod, shl;
    logic [WIDTH-1:0]   mplier, mplier_n, res, res_n, op_res;
    logic [WIDTH:0]     sum, dif;
    logic               valid, valid_n, zero, zero_n, neg, neg_n, carry, carry_n, ovf, ovf_n;
    logic               op_carry, op_ovf, big_shift, ready, accept;

    always_comb begin
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        dif       = {1'b0, bus.a} - {1'b0, bus.b};
        shl       = {{WIDTH{1'b0}}, bus.a} << bus.b;
        big_shift = {1'b0, bus.b} >= (WIDTH + 1)'(WIDTH);
        op_res    = '0;
        op_carry  = 1'b0;
        op_ovf    = 1'b0;
        case (bus.opcode)
            3'b000: begin
                op_res   = sum[WIDTH-1:0];
                op_carry = sum[WIDTH];
                op_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b001: begin
                op_res   = dif[WIDTH-1:0];
                op_carry = dif[WIDTH];
                op_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b010: op_res = bus.a & bus.b;
            3'b011: op_res = bus.a | bus.b;
            3'b100: op_res = bus.a ^ bus.b;
            3'b101: op_res = ~bus.a;
            3'b110: begin
                op_res   = big_shift ? '0 : shl[WIDTH-1:0];
                op_carry = big_shift ? |bus.a : |shl[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
`ifdef ALU_SAT_EN
        // Overflow direction always follows A's sign for both ADD and SUB
        if (op_ovf) op_res = bus.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    assign prod   = acc + (mplier[0] ? mcand : '0);
    assign ready  = (state == IDLE) && (!valid || bus.out_ready);
    assign accept = bus.in_valid && ready;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        res_n    = res;
        zero_n   = zero;
        neg_n    = neg;
        carry_n  = carry;
        ovf_n    = ovf;
        valid_n  = valid && !bus.out_ready;
        if (state == IDLE) begin
            if (accept && bus.opcode == 3'b111) begin
                state_n  = MUL;
                cnt_n    = CW'(WIDTH);
                acc_n    = '0;
                mcand_n  = {{WIDTH{1'b0}}, bus.a};
                mplier_n = bus.b;
            end else if (accept) begin
                res_n   = op_res;
                zero_n  = op_res == '0;
                neg_n   = op_res[WIDTH-1];
                carry_n = op_carry;
                ovf_n   = op_ovf;
                valid_n = 1'b1;
            end
        end else begin
            acc_n    = prod;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt - CW'(1);
            // Final iteration folds straight into the result register
            if (cnt == CW'(1)) begin
                state_n = IDLE;
                res_n   = prod[WIDTH-1:0];
                zero_n  = prod[WIDTH-1:0] == '0;
                neg_n   = prod[WIDTH-1];
                carry_n = |prod[2*WIDTH-1:WIDTH];
                ovf_n   = 1'b0;
                valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            res    <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            res    <= res_n;
            zero   <= zero_n;
            neg    <= neg_n;
            carry  <= carry_n;
            ovf    <= ovf_n;
            valid  <= valid_n;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid;
    assign bus.result     = res;
    assign bus.flag_zero  = zero;
    assign bus.flag_neg   = neg;
    assign bus.flag_carry = carry;
    assign bus.flag_ovf   = ovf;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;

    alu_pipe_if #(.WIDTH(8)) bus();

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = x;
        bus.b        = y;
        step();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [3:0] flags();
        return {bus.flag_zero, bus.flag_neg, bus.flag_carry, bus.flag_ovf};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.opcode = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        checks++;
        if (bus.result !== 8'h00) begin fails++; $display("FAIL reset_result got %h exp 00", bus.result); end
        checks++;
        if (flags() !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b exp 0000", flags()); end
        checks++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_add();
        issue(3'b000, 8'hFF, 8'h01);
        checks++;
        if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %b exp 1", bus.out_valid); end
        checks++;
        if (bus.result !== 8'h00) begin fails++; $display("FAIL add_result got %h exp 00", bus.result); end
        checks++;
        if (flags() !== 4'b1010) begin fails++; $display("FAIL add_flags got %b exp 1010", flags()); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL add_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_sub();
        logic [7:0] er;
        logic [3:0] ef;
`ifdef ALU_SAT_EN
        er = 8'h80;
        ef = 4'b0101;
`else
        er = 8'h7F;
        ef = 4'b0001;
`endif
        issue(3'b001, 8'h80, 8'h01);
        checks++;
        if (bus.result !== er) begin fails++; $display("FAIL sub_result got %h exp %h", bus.result, er); end
        checks++;
        if (flags() !== ef) begin fails++; $display("FAIL sub_flags got %b exp %b", flags(), ef); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] t_op [10] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b110, 3'b000, 3'b001, 3'b110, 3'b000};
        logic [7:0] t_a  [10] = '{8'hF0, 8'hF0, 8'hAA, 8'h0F, 8'h81, 8'h81, 8'h7F, 8'h00, 8'h01, 8'h80};
        logic [7:0] t_b  [10] = '{8'h3C, 8'h0C, 8'hAA, 8'h55, 8'h01, 8'h08, 8'h01, 8'h01, 8'h07, 8'h80};
`ifdef ALU_SAT_EN
        logic [7:0] t_r  [10] = '{8'h30, 8'hFC, 8'h00, 8'hF0, 8'h02, 8'h00, 8'h7F, 8'hFF, 8'h80, 8'h80};
        logic [3:0] t_f  [10] = '{4'b0000, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b1010, 4'b0001, 4'b0110, 4'b0100, 4'b0111};
`else
        logic [7:0] t_r  [10] = '{8'h30, 8'hFC, 8'h00, 8'hF0, 8'h02, 8'h00, 8'h80, 8'hFF, 8'h80, 8'h00};
        logic [3:0] t_f  [10] = '{4'b0000, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b1010, 4'b0101, 4'b0110, 4'b0100, 4'b1011};
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.opcode = t_op[i];
            bus.a = t_a[i];
            bus.b = t_b[i];
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== t_r[i])
                begin fails++; $display("FAIL b2b_result[%0d] got %b/%h exp 1/%h", i, bus.out_valid, bus.result, t_r[i]); end
            checks++;
            if (flags() !== t_f[i]) begin fails++; $display("FAIL b2b_flags[%0d] got %b exp %b", i, flags(), t_f[i]); end
            checks++;
            if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul();
        int lat;
        int busy;
        bus.out_ready = 1'b1;
        issue(3'b111, 8'h0D, 8'h0B);
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        lat = 1;
        busy = 0;
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready === 1'b0) busy++;
            step();
            lat++;
        end
        checks++;
        if (lat != 9) begin fails++; $display("FAIL mul_latency got %0d exp 9", lat); end
        checks++;
        if (busy != 8) begin fails++; $display("FAIL mul_busy got %0d exp 8", busy); end
        checks++;
        if (bus.result !== 8'h8F || flags() !== 4'b0100)
            begin fails++; $display("FAIL mul_0d_0b got %h/%b exp 8f/0100", bus.result, flags()); end
        issue(3'b111, 8'h14, 8'h14);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat != 9 || bus.result !== 8'h90 || flags() !== 4'b0110)
            begin fails++; $display("FAIL mul_14_14 got lat %0d %h/%b exp lat 9 90/0110", lat, bus.result, flags()); end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        issue(3'b000, 8'h03, 8'h04);
        bus.in_valid = 1'b1;
        bus.opcode = 3'b010;
        bus.a = 8'hF0;
        bus.b = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== 8'h07 || bus.in_ready !== 1'b0)
                begin fails++; $display("FAIL hold[%0d] got v%b r%h rdy%b exp v1 r07 rdy0", i, bus.out_valid, bus.result, bus.in_ready); end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL release_ready got %b exp 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'h30)
            begin fails++; $display("FAIL release_result got v%b %h exp v1 30", bus.out_valid, bus.result); end
        step();
    endtask

    task automatic test_reset_mid_mul();
        logic stale;
        bus.out_ready = 1'b1;
        issue(3'b111, 8'h0D, 8'h0B);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 8'h00 || flags() !== 4'b0000)
            begin fails++; $display("FAIL mid_rst_state got v%b %h/%b exp v0 00/0000", bus.out_valid, bus.result, flags()); end
        checks++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready got %b exp 1", bus.in_ready); end
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin fails++; $display("FAIL mid_rst_stale got %b exp 0", stale); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end
endmodule
